wb_regfile: RTL
===============

# wb_regfile

Write-back sink of the five-stage pipeline. Holds the 32 general-purpose registers and the HI/LO pair. Commits the register and HI/LO writes delivered by the MEM/WB pipeline register. Serves two combinational GPR read ports to the decode stage and a HI/LO read port to the execute stage, with optional same-cycle write-to-read bypass.

## Interface
Parameters:
- DATA_W, 32, register data width (RegBus)
- ADDR_W, 5, register address width (RegAddrBus)
- NREGS, 32, number of GPRs; must equal 2**ADDR_W

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous and active-high
- we  in  1  GPR write enable (from wb_wreg)
- waddr  in  ADDR_W  GPR write address (from wb_wd)
- wdata  in  DATA_W  GPR write data (from wb_wdata)
- whilo  in  1  HI/LO write enable (from wb_whilo)
- hi_i  in  DATA_W  HI write data (from wb_hi)
- lo_i  in  DATA_W  LO write data (from wb_lo)
- re1  in  1  read port 1 enable (decode)
- raddr1  in  ADDR_W  read port 1 address
- rdata1  out  DATA_W  read port 1 data
- re2  in  1  read port 2 enable (decode)
- raddr2  in  ADDR_W  read port 2 address
- rdata2  out  DATA_W  read port 2 data
- hi_o  out  DATA_W  current HI value (execute)
- lo_o  out  DATA_W  current LO value (execute)

## Operation
- GPR storage: NREGS x DATA_W flops. Register 0 is hardwired to zero: writes with waddr==0 are discarded, and reads of address 0 return 0.
- GPR write: at a rising clk with rst low, if we=1 and waddr!=0, then regs[waddr] <= wdata.
- HI/LO write: at a rising clk with rst low, if whilo=1, then hi <= hi_i and lo <= lo_i together. HI and LO are never written separately.
- Read port n (n=1,2) is combinational. Priority order:
  1. rst=1 -> 0
  2. ren=0 -> 0
  3. raddrn==0 -> 0
  4. bypass hit (see Configuration) -> wdata
  5. otherwise -> regs[raddrn]
- hi_o/lo_o are combinational. Priority order:
  1. rst=1 -> 0
  2. bypass hit (whilo=1) -> hi_i/lo_i
  3. otherwise -> stored hi/lo
- The block has no stall input. Stalls and bubbles arrive from upstream as we=0 and whilo=0.
- Both read ports may address the same register. Either may also match waddr. Every port resolves independently.

## Timing
- Reset: asserting rst asynchronously clears all GPRs, HI and LO to 0. While rst=1, rdata1, rdata2, hi_o and lo_o are 0.
- Any write presented in a cycle during which rst is high is lost. Reset deasserting mid-pipeline causes no spurious writes; the first commit happens at the first rising edge after deassertion with we or whilo high.
- Write latency is 1 edge: the value is visible from stored state in the cycle after the edge.
- Read latency is 0 cycles (combinational from address, enable and, with bypass, the write inputs).
- Two writes to the same address on consecutive cycles: the later wins. No write merging.

## Configuration
- Macro WB_BYPASS_EN.
- Defined: a read port hits when ren=1, raddrn!=0, we=1 and waddr==raddrn; it returns wdata in the same cycle as the write. hi_o/lo_o return hi_i/lo_i whenever whilo=1. The decode stage sees a write-back result in the same cycle, so WB-to-ID needs no forwarding.
- Undefined: no bypass. Reads always return stored state, so a same-cycle write becomes visible one cycle later. The hazard unit must then stall decode one cycle on a WB-to-ID address match.

## Test plan
- Reset: write 0xDEADBEEF to r5, then pulse rst high mid-cycle. Required: rdata1 (raddr1=5, re1=1) reads 0 immediately and stays 0 after reset releases. hi_o and lo_o read 0.
- r0 immutable: we=1, waddr=0, wdata=0xFFFFFFFF for one edge, then read r0 on both ports. Required: 0 on both ports. Also run with the write active in the same cycle as the read: still 0.
- Basic write/read: write r3=0x12345678, then r31=0xA5A5A5A5 on consecutive edges. Next cycle read raddr1=3, raddr2=31. Required: 0x12345678 and 0xA5A5A5A5. With re2=0: rdata2=0.
- Bypass: r7 holds 0x11. In one cycle drive we=1, waddr=7, wdata=0x22 with raddr1=raddr2=7. Required with WB_BYPASS_EN: both ports read 0x22 in that cycle. Required without it: both read 0x11, then 0x22 after the edge.
- HI/LO: whilo=1, hi_i=0xCAFE0000, lo_i=0x0000BEEF. Required with bypass: same-cycle hi_o/lo_o show the new values. Required in all builds: the new values hold after the edge. With whilo=0 and changing hi_i, the outputs are unchanged.
- Back-to-back: write r9=1, then r9=2, then r9=3 on three consecutive edges. Required: r9 reads 3 afterwards and no other register is modified (full 32-register sweep).

Source files
------------

// File: rtl/wb_regfile.sv
// Purpose: write-back register file; 32 GPRs (r0 hardwired to zero), HI/LO pair, two GPR read ports, one HI/LO read port.
// Latency: writes commit on the rising edge of clk; reads are combinational (0 cycles). Optional bypass is controlled by macro WB_BYPASS_EN.
// Backpressure: none. A write is accepted on every cycle it is presented; stalls arrive upstream as we=0 / whilo=0.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

`ifdef WB_BYPASS_EN
    // Same-cycle write data is forwarded to readers, so decode needs no WB-to-ID stall.
    localparam logic BYPASS = 1'b1;
`else
    // Readers only ever see stored state; decode must stall one cycle on a WB-to-ID match.
    localparam logic BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    // A GPR write to address zero is dropped, which keeps r0 permanently zero.
    logic gpr_wr;
    assign gpr_wr = we && (waddr != '0);

    // GPR storage: cleared by reset, one write per edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (gpr_wr) begin
            regs[waddr] <= wdata;
        end
    end

    // HI and LO always update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (whilo) begin
            hi_q <= hi_i;
            lo_q <= lo_i;
        end
    end

    // Read port 1: reset, disable and r0 force zero; then optional bypass; then stored value.
    always_comb begin
        rdata1 = '0;
        if (rst || !re1 || (raddr1 == '0)) begin
            rdata1 = '0;
        end else if (BYPASS && gpr_wr && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = regs[raddr1];
        end
    end

    // Read port 2: resolved independently with the same priority as port 1.
    always_comb begin
        rdata2 = '0;
        if (rst || !re2 || (raddr2 == '0)) begin
            rdata2 = '0;
        end else if (BYPASS && gpr_wr && (waddr == raddr2)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = regs[raddr2];
        end
    end

    // HI/LO read: zero in reset, optional same-cycle bypass, else stored pair.
    always_comb begin
        hi_o = '0;
        lo_o = '0;
        if (rst) begin
            hi_o = '0;
            lo_o = '0;
        end else if (BYPASS && whilo) begin
            hi_o = hi_i;
            lo_o = lo_i;
        end else begin
            hi_o = hi_q;
            lo_o = lo_q;
        end
    end

endmodule
